// File: rtl/glip_upscale.sv
// Narrow-to-wide collector: pairs two IN_SIZE-bit words into one 2*IN_SIZE-bit word.
// Define GLIP_UPSCALE_FLUSH_EN to add the flush input and the out_partial output.
module glip_upscale #(
   parameter int IN_SIZE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_SIZE-1:0]   in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [2*IN_SIZE-1:0] out_data,
   output logic                 out_valid,
`ifdef GLIP_UPSCALE_FLUSH_EN
   input  logic                 flush,
   output logic                 out_partial,
`endif
   input  logic                 out_ready
);

   typedef enum logic {WAIT_LOW, HAVE_LOW} state_t;

   state_t               state_q, state_d;
   logic [IN_SIZE-1:0]   lowHalf_q, lowHalf_d;
   logic [2*IN_SIZE-1:0] outData_q, outData_d;
   logic                 outValid_q, outValid_d;
   logic                 outPartial_q, outPartial_d;
   logic                 outFree;
   logic                 inXfer;
   logic                 flushReq;

`ifdef GLIP_UPSCALE_FLUSH_EN
   assign flushReq = flush;
`else
   assign flushReq = 1'b0;
`endif

   // The output register can take a new word when it is empty or draining now.
   assign outFree  = !outValid_q || out_ready;
   assign in_ready = (state_q == WAIT_LOW) ? 1'b1 : outFree;
   assign inXfer   = in_valid && in_ready;

   always_comb begin
      state_d      = state_q;
      lowHalf_d    = lowHalf_q;
      outData_d    = outData_q;
      outValid_d   = outValid_q && !out_ready;
      outPartial_d = outPartial_q;
      case (state_q)
         WAIT_LOW: begin
            if (inXfer) begin
               lowHalf_d = in_data;
               state_d   = HAVE_LOW;
            end
         end
         HAVE_LOW: begin
            // An upper-half transfer always wins over a simultaneous flush.
            if (inXfer) begin
               outData_d    = {in_data, lowHalf_q};
               outValid_d   = 1'b1;
               outPartial_d = 1'b0;
               state_d      = WAIT_LOW;
            end else if (flushReq && outFree) begin
               outData_d    = {{IN_SIZE{1'b0}}, lowHalf_q};
               outValid_d   = 1'b1;
               outPartial_d = 1'b1;
               state_d      = WAIT_LOW;
            end
         end
         default: state_d = WAIT_LOW;
      endcase
   end

   // Control state is reset; the data registers are not.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WAIT_LOW;
         outValid_q   <= 1'b0;
         outPartial_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         outValid_q   <= outValid_d;
         outPartial_q <= outPartial_d;
      end
      lowHalf_q <= lowHalf_d;
      outData_q <= outData_d;
   end

   assign out_data  = outData_q;
   assign out_valid = outValid_q;
`ifdef GLIP_UPSCALE_FLUSH_EN
   assign out_partial = outPartial_q;
`endif

endmodule

// File: doc/glip_upscale.md
GLIP_UPSCALE -- requirements
Module: glip_upscale

Interface
REQ-001 The block SHALL have parameter IN_SIZE, default 16, giving the input width in bits; the output width is 2*IN_SIZE.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: one clock, reset synchronous and active-high.
REQ-004 The block SHALL have port in_data, input, IN_SIZE bits: narrow input word.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port out_data, output, 2*IN_SIZE bits: assembled wide word.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the sink accepts out_data this cycle.
REQ-010 The ports flush (input, 1 bit: emit a pending half word) and out_partial (output, 1 bit: out_data upper half is zero padding) SHALL exist only when GLIP_UPSCALE_FLUSH_EN is defined.

Function
REQ-011 A transfer SHALL occur on a port exactly when its valid and ready are both high at a rising clk edge.
REQ-012 The collector SHALL have two states: WAIT_LOW (no half word held) and HAVE_LOW (lower half held in an internal register).
REQ-013 In WAIT_LOW, in_ready SHALL be 1; an input transfer stores in_data as the lower half and moves to HAVE_LOW.
REQ-014 In HAVE_LOW, in_ready SHALL be 1 unless out_valid=1 and out_ready=0; it is combinationally dependent on out_ready.
REQ-015 An input transfer in HAVE_LOW SHALL load the output register with {in_data, lower}, set out_valid=1 on the next cycle, and return to WAIT_LOW.
REQ-016 First-accepted word SHALL occupy out_data[IN_SIZE-1:0]; second-accepted word SHALL occupy out_data[2*IN_SIZE-1:IN_SIZE].
REQ-017 Latency SHALL be one cycle from the second input transfer to out_valid=1.
REQ-018 With in_valid and out_ready held at 1, the block SHALL accept one input word every cycle and emit one output word every second cycle, with no bubbles.
REQ-019 out_valid SHALL clear after an output transfer unless the output register is reloaded in the same cycle, in which case out_valid stays 1 with the new data.
REQ-020 out_data and out_valid SHALL be registered outputs and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-021 Accepting a lower half SHALL never depend on the output register, so a lower half may be accepted while a previous wide word is stalled.
REQ-022 in_data SHALL be ignored when no input transfer occurs; out_ready SHALL be ignored when out_valid=0.

Reset
REQ-023 While rst=1, the state SHALL be WAIT_LOW, out_valid=0 and out_partial=0 (when present); the data registers are not reset.
REQ-024 Reset in HAVE_LOW SHALL discard the held lower half, and reset with out_valid=1 SHALL drop the pending wide word.
REQ-025 in_ready SHALL read 1 in the first cycle after rst deasserts.

Configuration
REQ-026 With GLIP_UPSCALE_FLUSH_EN defined, flush=1 in HAVE_LOW SHALL load {IN_SIZE zeros, lower} with out_partial=1 and return to WAIT_LOW. This happens only when no input transfer occurs that cycle and the output register is free or draining.
REQ-027 With GLIP_UPSCALE_FLUSH_EN defined, an upper-half input transfer SHALL take priority over a simultaneous flush, the flush SHALL be ignored in WAIT_LOW, and out_partial=0 for every full word.
REQ-028 With GLIP_UPSCALE_FLUSH_EN undefined, the flush and out_partial ports SHALL be absent and the behaviour SHALL be exactly as REQ-011..REQ-025.

Verification (IN_SIZE=16)
REQ-029 Inputs 0x1111, 0x2222 on consecutive cycles with out_ready=1 -> out_data=0x22221111 with out_valid=1 for exactly one cycle, one cycle after the second transfer.
REQ-030 Streaming 0x0001..0x0008 back-to-back with out_ready=1 -> in_ready stays 1, outputs 0x00020001, 0x00040003, 0x00060005, 0x00080007.
REQ-031 Output 0xBBBBAAAA stalled (out_ready=0) and input 0xCCCC offered -> 0xCCCC accepted. Input 0xDDDD is then held off (in_ready=0) until out_ready=1. When out_ready=1 -> 0xBBBBAAAA is emitted, then 0xDDDDCCCC.
REQ-032 0x5555 accepted, then rst pulsed for one cycle, then inputs 0x6666, 0x7777 -> only 0x77776666 is emitted.
REQ-033 With the macro defined: 0x1234 accepted, then flush=1 with in_valid=0 -> out_data=0x00001234 and out_partial=1. Next, 0xAAAA then 0xBBBB -> 0xBBBBAAAA with out_partial=0.
REQ-034 With the macro defined: in HAVE_LOW with lower 0x0101, flush=1 and input 0x0202 in the same cycle -> out_data=0x02020101, out_partial=0, no partial word emitted.
